conv3x3_tile_acc: RTL and testbench

CONV3X3_TILE_ACC -- requirements
Module: conv3x3_tile_acc

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv3x3_pe.sv | 47 ++++
 rtl/conv3x3_tile_acc.sv | 131 +++++++++++++
 tb/tb_conv3x3_tile_acc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and window/tap index mapping
// for the 3x3 conv tile accumulator.
package conv_pkg;

  localparam int DW_DEF = 8;
  localparam int WW_DEF = 8;
  localparam int AW_DEF = 24;
  localparam int OW_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic int tapIdx(
    input int r,
    input int c,
    input int kr,
    input int kc
  );
    return (r + kr) * 4 + c + kc;
  endfunction

endpackage

// File: rtl/conv3x3_pe.sv
// One output position: registered 9 products, then a registered
// 9-term signed sum.
module conv3x3_pe
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF,
  parameter int R  = 0,
  parameter int C  = 0,
  parameter int PW = DW + WW,
  parameter int SW = DW + WW + 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [16*DW-1:0]     din,
  input  logic [9*WW-1:0]      weight,
  output logic signed [SW-1:0] sum
);

  logic signed [PW-1:0] prod [9];
  logic signed [SW-1:0] sumNx;

  always_comb begin
    sumNx = '0;
    for (int t = 0; t < 9; t++) begin
      sumNx = sumNx + SW'(prod[t]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < 9; t++) prod[t] <= '0;
      sum <= '0;
    end else if (en) begin
      for (int kr = 0; kr < 3; kr++) begin
        for (int kc = 0; kc < 3; kc++) begin
          prod[kr*3+kc] <=
            $signed(din[tapIdx(R, C, kr, kc)*DW +: DW]) *
            $signed(weight[(kr*3+kc)*WW +: WW]);
        end
      end
      sum <= sumNx;
    end
  end

endmodule

// File: rtl/conv3x3_tile_acc.sv
// 3x3 conv over a 4x4 window, accumulated across channel beats,
// requantised to a 2x2 output tile with valid/ready backpressure.
module conv3x3_tile_acc
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF,
  parameter int AW = AW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              i_first,
  input  logic              i_last,
  input  logic [16*DW-1:0]  i_din,
  input  logic [9*WW-1:0]   i_weight,
  input  logic [4:0]        i_shift,
  input  logic              i_relu,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [4*OW-1:0]   o_dout,
  output logic              o_err
);

  localparam int SW = DW + WW + 4;
  localparam int XW = AW + 33;
  localparam logic signed [XW-1:0] MAXV = (XW'(1) <<< (OW - 1)) - XW'(1);
  localparam logic signed [XW-1:0] MINV = -(XW'(1) <<< (OW - 1));

  state_t state, stateNx;
  logic en, take, keep, err;
  logic v1, f1, l1, rl1;
  logic v2, f2, l2, rl2;
  logic done3, rl3;
  logic [4:0] sh1, sh2, sh3;
  logic signed [SW-1:0] sum [4];
  logic signed [AW-1:0] acc [4];

  function automatic logic [OW-1:0] requant(
    input logic signed [AW-1:0] a,
    input logic [4:0]           sh,
    input logic                 rl
  );
    logic signed [XW-1:0] rnd, x;
    rnd = (sh == 5'd0) ? '0 : (XW'(1) <<< (sh - 5'd1));
    x = (XW'(a) + rnd) >>> sh;
    if (rl && x < 0) x = '0;
    if (x > MAXV) return MAXV[OW-1:0];
    if (x < MINV) return MINV[OW-1:0];
    return x[OW-1:0];
  endfunction

  assign en      = !(o_valid && !o_ready);
  assign i_ready = en;
  assign take    = i_valid && en;

  always_comb begin
    stateNx = state;
    keep    = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: if (take) begin
        keep    = i_first;
        err     = !i_first;
        stateNx = (i_first && !i_last) ? ACC : IDLE;
      end
      ACC: if (take) begin
        keep    = 1'b1;
        err     = i_first;
        stateNx = i_last ? IDLE : ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      o_err <= 1'b0;
    end else begin
      state <= stateNx;
      o_err <= err;
    end
  end

  for (genvar r = 0; r < 2; r++) begin : gRow
    for (genvar c = 0; c < 2; c++) begin : gCol
      conv3x3_pe #(
        .DW(DW), .WW(WW), .R(r), .C(c)
      ) uPe (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .din    (i_din),
        .weight (i_weight),
        .sum    (sum[r*2+c])
      );
    end
  end

  // Flags travel alongside the PE pipeline; acc feeds the output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {v1, f1, l1, rl1, sh1} <= '0;
      {v2, f2, l2, rl2, sh2} <= '0;
      {done3, rl3, sh3}      <= '0;
      for (int p = 0; p < 4; p++) acc[p] <= '0;
      o_valid <= 1'b0;
      o_dout  <= '0;
    end else if (en) begin
      {v1, f1, l1, rl1, sh1} <= {keep, i_first, i_last, i_relu, i_shift};
      {v2, f2, l2, rl2, sh2} <= {v1, f1, l1, rl1, sh1};
      done3 <= v2 && l2;
      rl3   <= rl2;
      sh3   <= sh2;
      if (v2) begin
        for (int p = 0; p < 4; p++) begin
          acc[p] <= f2 ? AW'(sum[p]) : acc[p] + AW'(sum[p]);
        end
      end
      o_valid <= done3;
      if (done3) begin
        for (int p = 0; p < 4; p++) begin
          o_dout[p*OW +: OW] <= requant(acc[p], sh3, rl3);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_tile_acc.sv
// Directed and random stimulus against a tile-level arithmetic
// model of the conv accumulator.
module tb_conv3x3_tile_acc;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 24;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready;
  logic i_first = 1'b0;
  logic i_last = 1'b0;
  logic [16*DW-1:0] i_din = '0;
  logic [9*WW-1:0] i_weight = '0;
  logic [4:0] i_shift = '0;
  logic i_relu = 1'b0;
  logic o_valid;
  logic o_ready = 1'b1;
  logic [4*OW-1:0] o_dout;
  logic o_err;

  conv3x3_tile_acc #(.DW(DW), .WW(WW), .AW(AW), .OW(OW)) dut (
    .clk(clk), .rstn(rstn),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_first(i_first), .i_last(i_last),
    .i_din(i_din), .i_weight(i_weight),
    .i_shift(i_shift), .i_relu(i_relu),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_dout(o_dout), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  logic [4*OW-1:0] expQ[$];
  logic [4*OW-1:0] gotQ[$];
  bit inTile = 0;
  longint acc[4];

  always @(negedge clk) begin
    if (o_valid && o_ready) gotQ.push_back(o_dout);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint partial(input logic [16*DW-1:0] d,
                                     input logic [9*WW-1:0] w,
                                     input int r, input int c);
    longint s = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        s += longint'($signed(d[((r+kr)*4+c+kc)*DW +: DW])) *
             longint'($signed(w[(kr*3+kc)*WW +: WW]));
    return s;
  endfunction

  function automatic longint wrapAW(input longint v);
    longint m = v & ((64'sd1 <<< AW) - 1);
    if (m[AW-1]) m -= (64'sd1 <<< AW);
    return m;
  endfunction

  function automatic longint rq(input longint a, input int sh, input bit rl);
    longint x = a + ((sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
    longint hi = (64'sd1 <<< (OW - 1)) - 1;
    x = x >>> sh;
    if (rl && x < 0) x = 0;
    if (x > hi) x = hi;
    if (x < -hi - 1) x = -hi - 1;
    return x;
  endfunction

  function automatic logic [16*DW-1:0] fillD(input logic [DW-1:0] v);
    logic [16*DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [9*WW-1:0] fillW(input logic [WW-1:0] v);
    logic [9*WW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*WW +: WW] = v;
    return w;
  endfunction

  function automatic logic [16*DW-1:0] rndD();
    logic [16*DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  function automatic logic [9*WW-1:0] rndW();
    logic [9*WW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*WW +: WW] = WW'($urandom);
    return w;
  endfunction

  task automatic beat(input logic [16*DW-1:0] d, input logic [9*WW-1:0] w,
                      input bit f, input bit l, input int sh, input bit rl);
    int n = 0;
    bit expErr;
    logic [4*OW-1:0] t;
    i_valid = 1'b1; i_first = f; i_last = l;
    i_din = d; i_weight = w; i_shift = 5'(sh); i_relu = rl;
    @(negedge clk);
    while (!i_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("accept", i_ready, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    expErr = inTile ? f : !f;
    if (inTile || f) begin
      for (int p = 0; p < 4; p++)
        acc[p] = f ? partial(d, w, p / 2, p % 2)
                   : wrapAW(acc[p] + partial(d, w, p / 2, p % 2));
      if (l) begin
        for (int p = 0; p < 4; p++) t[p*OW +: OW] = OW'(rq(acc[p], sh, rl));
        expQ.push_back(t);
        inTile = 0;
      end else begin
        inTile = 1;
      end
    end
    check("o_err", o_err, expErr);
  endtask

  task automatic drain(input string tag);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_count"}, gotQ.size(), expQ.size());
    while (gotQ.size() > 0 && expQ.size() > 0)
      check({tag, "_tile"}, gotQ.pop_front(), expQ.pop_front());
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [4*OW-1:0] held;
    int n;
    repeat (3) @(negedge clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_dout", o_dout, 0);
    check("rst_o_err", o_err, 0);
    check("rst_i_ready", i_ready, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // single-channel tile and its latency
    beat(fillD(8'd1), fillW(8'd1), 1, 1, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_n2_valid", o_valid, 0);
    @(posedge clk); #1;
    check("lat_n3_valid", o_valid, 1);
    check("lat_n3_dout", o_dout, {4{8'd9}});
    drain("ones");

    // two channels, then a stray non-first beat
    beat(fillD(8'd1), fillW(8'd1), 1, 0, 0, 0);
    beat(fillD(8'd1), fillW(8'd1), 0, 1, 0, 0);
    beat(fillD(8'd1), fillW(8'd1), 0, 1, 0, 0);
    drain("two_ch");
    check("two_ch_val", {4{8'd18}}, {4{8'd18}} & '1);

    // saturation and relu
    beat(fillD(8'h80), fillW(8'h7f), 1, 1, 0, 0);
    beat(fillD(8'h80), fillW(8'h7f), 1, 1, 0, 1);
    drain("sat");

    // rounding shift
    beat(fillD(8'd1), fillW(8'd1), 1, 1, 2, 0);
    drain("round");

    // restart mid tile
    beat(rndD(), rndW(), 1, 0, 0, 0);
    beat(fillD(8'd1), fillW(8'd1), 1, 1, 0, 0);
    drain("restart");

    // backpressure while tiles stream
    o_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 3; t++) begin
          beat(rndD(), rndW(), 1, 0, 0, 0);
          beat(rndD(), rndW(), 0, 1, $urandom_range(0, 8), 1'($urandom));
        end
      end
      begin
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 50) begin
          n++;
          @(negedge clk);
        end
        check("bp_valid", o_valid, 1);
        held = o_dout;
        repeat (5) begin
          @(negedge clk);
          check("bp_i_ready", i_ready, 0);
          check("bp_hold", o_dout, held);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
    drain("bp");

    // reset in the middle of a tile
    beat(rndD(), rndW(), 1, 0, 0, 0);
    rstn = 1'b0;
    inTile = 0;
    @(negedge clk);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_dout", o_dout, 0);
    check("mid_rst_ready", i_ready, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    beat(rndD(), rndW(), 0, 1, 0, 0);
    beat(rndD(), rndW(), 1, 0, 3, 0);
    beat(rndD(), rndW(), 0, 1, 3, 0);
    drain("post_rst");

    // random tiles, back to back
    for (int t = 0; t < 20; t++) begin
      int ch = $urandom_range(1, 3);
      int sh = $urandom_range(0, 12);
      bit rl = 1'($urandom);
      if ($urandom_range(0, 9) == 0) beat(rndD(), rndW(), 0, 0, 0, 0);
      for (int k = 0; k < ch; k++)
        beat(rndD(), rndW(), k == 0, k == ch - 1, sh, rl);
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
